// File: rtl/fetch_buffer_pkg.sv
// Shared types for the instruction prefetch stage: ITIM request/response buses,
// FIFO entry layout, front-end state encoding and the instruction size helper.
package fetch_wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fbuf_entry_type;

    typedef enum logic [1:0] {
        ST_RUN         = 2'd0,
        ST_FENCE_DRAIN = 2'd1,
        ST_FENCE_WAIT  = 2'd2
    } fetch_state_type;

    localparam int FCNT_W = 16;

    typedef struct packed {
        fetch_state_type   state;
        logic [31:0]       fetch_pc;
        logic [31:0]       req_pc;
        logic              pend;
        logic              discard;
        logic [FCNT_W-1:0] fcnt;
        logic              active;
    } fetch_reg_type;

    localparam fetch_reg_type FETCH_INIT = '{
        state:    ST_RUN,
        fetch_pc: 32'h0,
        req_pc:   32'h0,
        pend:     1'b0,
        discard:  1'b0,
        fcnt:     '0,
        active:   1'b0
    };

    // RVC: low bits 2'b11 mark a full 32-bit instruction, anything else is 16-bit.
    function automatic logic [31:0] instr_size(input logic [31:0] instr);
        return (instr[1:0] == 2'b11) ? 32'd4 : 32'd2;
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// ITIM request/response bundle between the fetch buffer (master) and the ITIM (slave).
interface fetch_buffer_if;
    import fetch_wires::*;

    mem_in_type  itim_in;
    mem_out_type itim_out;

    modport master (output itim_in, input itim_out);
    modport slave  (input itim_in, output itim_out);
endinterface

// File: rtl/fetch_buffer_fifo.sv
// Register FIFO of {pc, instr} entries; head entry is presented combinationally.
module fetch_fifo
    import fetch_wires::*;
#(
    parameter int depth = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  fbuf_entry_type          wdata,
    output fbuf_entry_type          rdata,
    output logic [$clog2(depth):0]  count
);
    localparam int AW = $clog2(depth);

    fbuf_entry_type mem_q [depth];
    logic [AW-1:0]  rd_q;
    logic [AW-1:0]  wr_q;
    logic [AW:0]    cnt_q;
    logic           do_push;
    logic           do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != (AW+1)'(depth)) || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: issues sequential ITIM fetches, queues responses for
// decode and handles redirects and fence.i with discard of stale responses.
module fetch_buffer
    import fetch_wires::*;
#(
    parameter int          fbuf_depth = 4,
    parameter logic [31:0] start_addr = 32'h0,
    parameter int          itim_depth = 6,
    parameter int          fence_wait = itim_depth + 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  redir_valid,
    input  logic [31:0]           redir_addr,
    input  logic                  redir_fence,
    input  logic                  deq_ready,
    output logic                  deq_valid,
    output logic [31:0]           deq_pc,
    output logic [31:0]           deq_instr,
    fetch_buffer_if.master        itim
);
    localparam int CW = $clog2(fbuf_depth) + 1;

    fetch_reg_type  r_q;
    fetch_reg_type  r_d;
    mem_in_type     req;
    fbuf_entry_type wdata;
    fbuf_entry_type rdata;
    logic [CW-1:0]  count;
    logic [CW:0]    count_next;
    logic           resp;
    logic           push;
    logic           pop;
    logic           flush;
    logic           issue;
    logic           fence_req;
    logic [31:0]    npc;

    fetch_fifo #(.depth(fbuf_depth)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .rdata (rdata),
        .count (count)
    );

    always_comb begin
        r_d        = r_q;
        r_d.active = 1'b1;
        resp       = r_q.pend && itim.itim_out.mem_ready;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        issue      = 1'b0;
        fence_req  = 1'b0;
        npc        = r_q.fetch_pc;
        wdata      = '{pc: r_q.req_pc, instr: itim.itim_out.mem_rdata};
        count_next = {1'b0, count};

        if (resp) begin
            r_d.pend    = 1'b0;
            r_d.discard = 1'b0;
        end

        // The fence wait counter keeps running even across plain redirects.
        if (r_q.state == ST_FENCE_WAIT) begin
            r_d.fcnt = r_q.fcnt - FCNT_W'(1);
            if (r_q.fcnt <= FCNT_W'(1)) begin
                r_d.state = ST_RUN;
                r_d.fcnt  = '0;
            end
        end

        if (redir_valid) begin
            flush        = 1'b1;
            r_d.fetch_pc = redir_addr & ~32'h1;
            r_d.discard  = r_q.pend && !itim.itim_out.mem_ready;
            if (redir_fence) begin
                r_d.state = ST_FENCE_DRAIN;
                r_d.fcnt  = '0;
            end
        end else begin
            push = resp && !r_q.discard;
            pop  = (count != '0) && deq_ready;
            if (push) begin
                npc          = r_q.req_pc + instr_size(itim.itim_out.mem_rdata);
                r_d.fetch_pc = npc;
            end
            count_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);

            if (r_q.state == ST_RUN) begin
                // Reserve a slot for the response before issuing.
                issue = r_q.active && !r_d.pend && (count_next < (CW+1)'(fbuf_depth));
                if (issue) begin
                    r_d.pend   = 1'b1;
                    r_d.req_pc = npc;
                end
            end else if ((r_q.state == ST_FENCE_DRAIN) && !r_q.pend) begin
                fence_req = 1'b1;
                r_d.fcnt  = FCNT_W'(fence_wait);
                r_d.state = (fence_wait == 0) ? ST_RUN : ST_FENCE_WAIT;
            end
        end

        req           = '0;
        req.mem_valid = issue || fence_req;
        req.mem_fence = fence_req;
        req.mem_instr = 1'b1;
        req.mem_addr  = fence_req ? r_q.fetch_pc : npc;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_q          <= FETCH_INIT;
            r_q.fetch_pc <= start_addr;
        end else begin
            r_q <= r_d;
        end
    end

    assign itim.itim_in = req;
    assign deq_valid    = (count != '0);
    assign deq_pc       = rdata.pc;
    assign deq_instr    = rdata.instr;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: ITIM model, program-order reference for request and
// dequeue streams, directed scenarios followed by randomized traffic.
module tb_fetch_buffer;
    import fetch_wires::*;

    logic        clock;
    logic        reset;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        redir_fence;
    logic        deq_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;

    fetch_buffer_if itim_bus();

    fetch_buffer #(
        .fbuf_depth (4),
        .start_addr (32'h0),
        .itim_depth (6),
        .fence_wait (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .redir_fence (redir_fence),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .deq_pc      (deq_pc),
        .deq_instr   (deq_instr),
        .itim        (itim_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic        c_rv, c_rf, c_dr;
    logic [31:0] c_ra;
    int          mode;
    int          next_lat;
    bit          rand_lat;
    bit          itim_pend;
    int          itim_wait;
    logic [31:0] itim_addr;
    logic [31:0] exp_req, exp_deq;
    logic        o_mv, o_mf, o_dv, o_mr;
    logic [31:0] o_ma, o_dpc, o_di;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Instruction image: mode 0 is the directed program, mode 1 a hashed mix of sizes.
    function automatic logic [31:0] memf(input logic [31:0] addr);
        logic [31:0] h;
        if (mode == 0) begin
            return (addr == 32'h100 || addr == 32'hFFFF_FFFE) ? 32'h0000_4501 : 32'h0000_0013;
        end
        h = addr * 32'h9E37_79B1;
        return {h[31:2], h[20] ? 2'b11 : {h[7], 1'b0}};
    endfunction

    function automatic logic [31:0] isz(input logic [31:0] instr);
        return (instr[1:0] == 2'b11) ? 32'd4 : 32'd2;
    endfunction

    task automatic cycle();
        bit ready;
        ready = itim_pend && (itim_wait == 0);
        itim_bus.itim_out.mem_ready = ready;
        itim_bus.itim_out.mem_rdata = ready ? memf(itim_addr) : 32'hDEAD_BEEF;
        redir_valid = c_rv;
        redir_addr  = c_ra;
        redir_fence = c_rf;
        deq_ready   = c_dr;
        #2;
        o_mv  = itim_bus.itim_in.mem_valid;
        o_mf  = itim_bus.itim_in.mem_fence;
        o_ma  = itim_bus.itim_in.mem_addr;
        o_dv  = deq_valid;
        o_dpc = deq_pc;
        o_di  = deq_instr;
        o_mr  = ready;

        chk("const_outputs", 32'(itim_bus.itim_in.mem_instr === 1'b1 &&
                                 itim_bus.itim_in.mem_wdata === 32'h0 &&
                                 itim_bus.itim_in.mem_wstrb === 4'h0), 32'd1);
        if (c_rv) begin
            chk("redir_no_req", 32'(o_mv), 32'd0);
            exp_deq = c_ra & ~32'h1;
        end else if (o_dv && c_dr) begin
            chk("deq_pc", o_dpc, exp_deq);
            chk("deq_instr", o_di, memf(exp_deq));
            exp_deq = exp_deq + isz(memf(exp_deq));
        end
        if (o_mv) begin
            chk("req_overlap", 32'(itim_pend && !ready), 32'd0);
            chk(o_mf ? "fence_addr" : "req_addr", o_ma, exp_req);
            if (!o_mf) exp_req = o_ma + isz(memf(o_ma));
        end
        if (c_rv) exp_req = c_ra & ~32'h1;

        if (ready) itim_pend = 1'b0;
        else if (itim_pend && itim_wait > 0) itim_wait--;
        if (o_mv && !o_mf) begin
            itim_pend = 1'b1;
            itim_addr = o_ma;
            itim_wait = rand_lat ? int'($urandom_range(0, 3)) : next_lat;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic redirect(input logic [31:0] addr, input logic fence);
        c_rv = 1'b1; c_ra = addr; c_rf = fence;
        cycle();
        c_rv = 1'b0; c_rf = 1'b0;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr, input logic exp_fence);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (o_mv) found = 1;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            chk(tag, o_ma, exp_addr);
            chk({tag, "_fence"}, 32'(o_mf), 32'(exp_fence));
        end
    endtask

    task automatic req_now(input string tag, input logic [31:0] exp_addr);
        cycle();
        chk({tag, "_valid"}, 32'(o_mv), 32'd1);
        chk(tag, o_ma, exp_addr);
    endtask

    initial begin
        int nreq;
        int gap;
        bit found;
        reset = 1'b0;
        c_rv = 0; c_rf = 0; c_dr = 1; c_ra = 0;
        mode = 0; next_lat = 0; rand_lat = 0;
        itim_pend = 0; itim_wait = 0; itim_addr = 0;
        exp_req = 32'h0; exp_deq = 32'h0;
        redir_valid = 0; redir_addr = 0; redir_fence = 0; deq_ready = 0;
        itim_bus.itim_out = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_deq_valid", 32'(deq_valid), 32'd0);
        chk("rst_deq_pc", deq_pc, 32'h0);
        chk("rst_deq_instr", deq_instr, 32'h0);
        chk("rst_mem_valid", 32'(itim_bus.itim_in.mem_valid), 32'd0);
        chk("rst_mem_fence", 32'(itim_bus.itim_in.mem_fence), 32'd0);
        reset = 1'b1;

        // Sequential 32-bit stream from start_addr
        wait_req("t1_req0", 32'h0, 1'b0);
        req_now("t1_req1", 32'h4);
        req_now("t1_req2", 32'h8);
        chk("t1_deq_pc0", o_dpc, 32'h0);
        chk("t1_deq_instr0", o_di, 32'h0000_0013);
        cycle();
        chk("t1_deq_pc1", o_dpc, 32'h4);

        // Compressed instruction sizing and address wrap
        redirect(32'h100, 1'b0);
        wait_req("t2_req0", 32'h100, 1'b0);
        req_now("t2_req1", 32'h102);
        req_now("t2_req2", 32'h106);
        redirect(32'hFFFF_FFFF, 1'b0);
        wait_req("t2_wrap0", 32'hFFFF_FFFE, 1'b0);
        req_now("t2_wrap1", 32'h0);

        // Backpressure: exactly fbuf_depth requests, then one per pop
        c_dr = 1'b0;
        redirect(32'h200, 1'b0);
        nreq = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (o_mv) nreq++;
        end
        chk("t3_fill_reqs", 32'(nreq), 32'd4);
        chk("t3_deq_valid", 32'(o_dv), 32'd1);
        chk("t3_idle", 32'(o_mv), 32'd0);
        c_dr = 1'b1;
        cycle();
        nreq = o_mv ? 1 : 0;
        c_dr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (o_mv) nreq++;
        end
        chk("t3_pop_reqs", 32'(nreq), 32'd1);

        // Redirect during a slow response: stale data discarded, refetch on its arrival
        redirect(32'h3C, 1'b0);
        wait_req("t4_req_3c", 32'h3C, 1'b0);
        next_lat = 5;
        req_now("t4_req_40", 32'h40);
        next_lat = 0;
        cycle();
        redirect(32'h200, 1'b0);
        chk("t4_pre_valid", 32'(o_dv), 32'd1);
        c_dr = 1'b1;
        cycle();
        chk("t4_flushed", 32'(o_dv), 32'd0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (o_mr) found = 1;
        end
        chk("t4_stale_ready_seen", 32'(found), 32'd1);
        chk("t4_refetch_valid", 32'(o_mv), 32'd1);
        chk("t4_refetch_addr", o_ma, 32'h200);
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            cycle();
            if (o_dv) found = 1;
        end
        chk("t4_head_seen", 32'(found), 32'd1);
        chk("t4_head_pc", o_dpc, 32'h200);

        // fence.i with nothing outstanding
        c_dr = 1'b0;
        repeat (12) cycle();
        redirect(32'h300, 1'b1);
        c_dr = 1'b1;
        wait_req("t5_fence", 32'h300, 1'b1);
        gap = 0;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (o_mv) found = 1;
            else gap++;
        end
        chk("t5_wait_cycles", 32'(gap), 32'd8);
        chk("t5_resume_addr", o_ma, 32'h300);
        chk("t5_resume_fence", 32'(o_mf), 32'd0);

        // Asynchronous reset in the middle of a miss
        c_dr = 1'b0;
        redirect(32'h80, 1'b0);
        wait_req("t6_req_80", 32'h80, 1'b0);
        next_lat = 10;
        cycle();
        next_lat = 0;
        cycle();
        chk("t6_pre_valid", 32'(o_dv), 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_async_deq_valid", 32'(deq_valid), 32'd0);
        chk("t6_async_mem_valid", 32'(itim_bus.itim_in.mem_valid), 32'd0);
        exp_req = 32'h0;
        exp_deq = 32'h0;
        itim_wait = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        c_dr = 1'b1;
        cycle();
        chk("t6_late_ready_presented", 32'(o_mr), 32'd1);
        wait_req("t6_restart", 32'h0, 1'b0);
        repeat (6) cycle();

        // Randomized traffic against the program-order model
        mode = 1;
        rand_lat = 1;
        redirect(32'h1000, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            c_dr = ($urandom_range(0, 9) < 7);
            c_rv = ($urandom_range(0, 99) < 3);
            c_rf = c_rv && ($urandom_range(0, 3) == 0);
            c_ra = $urandom & 32'h0000_3FFF;
            cycle();
        end
        c_rv = 1'b0;
        c_rf = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
